boreal_eeg_spi_rx: RTL and testbench
====================================

BOREAL_EEG_SPI_RX -- requirements
Module: boreal_eeg_spi_rx

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 4: SCLK half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have parameter NUM_CH, default 8: number of 24-bit channel words per frame, following the status word.
REQ-003 SHALL have parameter CH_SEL, default 0: channel index forwarded; legal range 0..NUM_CH-1.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1: when high, new frames may start.
REQ-007 SHALL have port drdy_n, input, 1: ADC data-ready, active-low, asynchronous to clk.
REQ-008 SHALL have port spi_miso, input, 1: ADC serial data, MSB first.
REQ-009 SHALL have port spi_sclk, output, 1: SPI clock, mode 1 (CPOL=0, CPHA=1).
REQ-010 SHALL have port spi_cs_n, output, 1: chip select, active-low.
REQ-011 SHALL have port raw_eeg_out, output, 24, signed: selected channel sample, held between frames.
REQ-012 SHALL have port data_valid, output, 1: one-cycle pulse when raw_eeg_out updates.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse when a frame is rejected.
REQ-014 SHALL have port overrun, output, 1: one-cycle pulse when a drdy_n falling edge is missed while busy.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-016 SHALL synchronise drdy_n through two flops and detect a falling edge on the synchronised value.
REQ-017 SHALL use states IDLE, CS_SETUP, SHIFT, CS_HOLD and PUBLISH.
REQ-018 SHALL move IDLE->CS_SETUP on a detected falling edge with enable=1, asserting spi_cs_n low in the same cycle.
REQ-019 SHALL stay in CS_SETUP for SCLK_DIV cycles with spi_sclk=0, then enter SHIFT.
REQ-020 In SHIFT, spi_sclk SHALL toggle every SCLK_DIV cycles, starting high, for exactly 24*(1+NUM_CH) pulses (216 by default).
REQ-021 SHALL sample spi_miso in the clk cycle in which spi_sclk goes high->low, shifting MSB first.
REQ-022 SHALL capture bits 0..23 as the status word and the bits of channel word CH_SEL as the sample; all other words are clocked and discarded.
REQ-023 After the last falling SCLK edge, SHALL hold spi_sclk=0 and spi_cs_n=0 for SCLK_DIV cycles (CS_HOLD), then release spi_cs_n high.
REQ-024 PUBLISH SHALL last one cycle: either raw_eeg_out is updated and data_valid=1, or frame_err=1 per REQ-032; then return to IDLE.
REQ-025 Total frame duration from CS_SETUP entry to IDLE SHALL be 2*SCLK_DIV + 2*SCLK_DIV*24*(1+NUM_CH) + 1 cycles.
REQ-026 A drdy_n falling edge detected while busy=1 SHALL pulse overrun for one cycle and SHALL NOT start or restart a frame.
REQ-027 Deasserting enable mid-frame SHALL NOT abort the frame; the FSM then stays in IDLE while enable=0, and edges seen then are ignored without overrun.
REQ-028 data_valid, frame_err and overrun SHALL never be high for more than one consecutive cycle; data_valid and frame_err SHALL be mutually exclusive.

Reset
REQ-029 On rst_n=0, the block SHALL immediately force IDLE, spi_cs_n=1, spi_sclk=0, raw_eeg_out=0, data_valid=0, frame_err=0, overrun=0, busy=0, and clear the shift register, bit counter, divider and synchroniser (to 1).
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no data_valid; the next frame SHALL start only on a fresh drdy_n falling edge after release.

Configuration
REQ-031 The macro BOREAL_STATUS_CHECK_EN SHALL control status-word checking.
REQ-032 With BOREAL_STATUS_CHECK_EN defined, a frame whose status bits [23:20] are not 4'b1100 SHALL pulse frame_err in PUBLISH and leave raw_eeg_out unchanged.
REQ-033 Without BOREAL_STATUS_CHECK_EN, every completed frame SHALL produce data_valid, and frame_err SHALL be tied to 0.

Verification
REQ-034 Defaults, status 0xC00000, ch0 0x008000 -> exactly 216 SCLK pulses, spi_cs_n high afterwards, raw_eeg_out=0x008000, data_valid high for one cycle.
REQ-035 CH_SEL=3, ch3=0x800001, other channels 0x7FFFFF -> raw_eeg_out=0x800001 (negative), one data_valid.
REQ-036 With BOREAL_STATUS_CHECK_EN, status 0x400000 -> frame_err pulse, no data_valid, raw_eeg_out keeps the prior 0x008000; without the macro -> data_valid is produced instead.
REQ-037 Second drdy_n falling edge 100 cycles into a frame -> one overrun pulse, and the frame still completes with 216 SCLK pulses.
REQ-038 rst_n low at SCLK pulse 50 -> spi_cs_n=1 and spi_sclk=0 immediately, no data_valid, and the next drdy_n edge yields a normal frame.
REQ-039 enable=0, three drdy_n edges -> spi_cs_n stays 1, with no overrun and no data_valid.

Source files
------------

// File: rtl/boreal_eeg_spi_rx.sv
// boreal_eeg_spi_rx
// SPI mode-1 frame reader for a multi-channel EEG ADC. A falling edge on the
// (asynchronous) drdy_n line starts one frame: a 24-bit status word followed by
// NUM_CH 24-bit channel words, MSB first. Only channel CH_SEL is kept and
// published on raw_eeg_out.
//
// Parameters: SCLK_DIV (SCLK half-period in clk cycles, 2..255), NUM_CH,
//             CH_SEL (0..NUM_CH-1).
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   enable            allows new frames to start
//   drdy_n            ADC data-ready (async, active-low)
//   spi_miso          ADC serial data
//   spi_sclk          SPI clock (CPOL=0, CPHA=1)
//   spi_cs_n          chip select, active-low
//   raw_eeg_out       selected channel sample (signed, held between frames)
//   data_valid        1-cycle pulse when raw_eeg_out updates
//   frame_err         1-cycle pulse when a frame is rejected
//   overrun           1-cycle pulse when a drdy_n edge arrives while busy
//   busy              high whenever the FSM is not idle
//
// Optional feature: define BOREAL_STATUS_CHECK_EN to reject frames whose
// status bits [23:20] are not 4'b1100. Without it frame_err is tied low.

module boreal_eeg_spi_rx #(
    parameter int SCLK_DIV = 4,
    parameter int NUM_CH   = 8,
    parameter int CH_SEL   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               drdy_n,
    input  logic               spi_miso,
    output logic               spi_sclk,
    output logic               spi_cs_n,
    output logic signed [23:0] raw_eeg_out,
    output logic               data_valid,
    output logic               frame_err,
    output logic               overrun,
    output logic               busy
);

    localparam int NBITS  = 24 * (1 + NUM_CH);
    localparam int BW     = $clog2(NBITS + 1);
    localparam int SEL_LO = 24 * (1 + CH_SEL);
    localparam int SEL_HI = SEL_LO + 24;

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, PUBLISH} state_t;

    state_t          state, state_nx;
    logic            sync1, sync2, drdy_prev;
    logic            drdy_fall;
    logic [7:0]      div_cnt;
    logic            div_last;
    logic            half;       // 0: SCLK high half-period, 1: low half-period
    logic [BW-1:0]   bit_cnt;
    logic [23:0]     sample_sr;
    logic            status_ok;
    logic            sample_edge;

    assign drdy_fall   = drdy_prev & ~sync2;
    assign div_last    = (div_cnt == 8'(SCLK_DIV - 1));
    // SCLK high->low transition happens on this edge; ADC data is stable here.
    assign sample_edge = (state == SHIFT) && div_last && !half;

`ifdef BOREAL_STATUS_CHECK_EN
    // Only the checked nibble of the status word is retained; the remaining
    // status bits are clocked through and discarded.
    logic [3:0] status_nib;
    assign status_ok = (status_nib == 4'b1100);
`else
    assign status_ok = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (drdy_fall && enable) state_nx = CS_SETUP;
            CS_SETUP: if (div_last) state_nx = SHIFT;
            SHIFT:    if (div_last && half && bit_cnt == BW'(NBITS)) state_nx = CS_HOLD;
            CS_HOLD:  if (div_last) state_nx = PUBLISH;
            PUBLISH:  state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        spi_cs_n   = !(state == CS_SETUP || state == SHIFT || state == CS_HOLD);
        spi_sclk   = (state == SHIFT) && !half;
        busy       = (state != IDLE);
        data_valid = (state == PUBLISH) && status_ok;
`ifdef BOREAL_STATUS_CHECK_EN
        frame_err  = (state == PUBLISH) && !status_ok;
`else
        frame_err  = 1'b0;
`endif
        // A new edge while any frame is in flight is dropped, never queued.
        overrun    = drdy_fall && (state != IDLE);
    end

    // Synchroniser, divider, bit counter and shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            drdy_prev   <= 1'b1;
            div_cnt     <= '0;
            half        <= 1'b0;
            bit_cnt     <= '0;
            sample_sr   <= '0;
            raw_eeg_out <= '0;
        end else begin
            sync1     <= drdy_n;
            sync2     <= sync1;
            drdy_prev <= sync2;

            if (state == IDLE || state == PUBLISH || div_last) div_cnt <= '0;
            else                                               div_cnt <= div_cnt + 8'd1;

            if (state != SHIFT)  half <= 1'b0;
            else if (div_last)   half <= ~half;

            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (sample_edge) begin
                bit_cnt <= bit_cnt + 1'b1;
                if (bit_cnt >= BW'(SEL_LO) && bit_cnt < BW'(SEL_HI))
                    sample_sr <= {sample_sr[22:0], spi_miso};
            end

            // Loaded on entry to PUBLISH so the new value coincides with data_valid.
            if (state == CS_HOLD && div_last && status_ok)
                raw_eeg_out <= sample_sr;
        end
    end

`ifdef BOREAL_STATUS_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             status_nib <= '0;
        else if (sample_edge && bit_cnt < BW'(4)) status_nib <= {status_nib[2:0], spi_miso};
    end
`endif

endmodule

// File: tb/tb_boreal_eeg_spi_rx.sv
module tb_boreal_eeg_spi_rx;
    localparam int D    = 4;
    localparam int NCH  = 8;
    localparam int SEL3 = 3;
    localparam int NB   = 24 * (1 + NCH);
    localparam int L    = 2 * D + 2 * D * NB + 1;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, drdy_n = 1'b1, spi_miso = 1'b0;
    logic sclk0, csn0, dv0, fe0, ov0, busy0;
    logic sclk3, csn3, dv3, fe3, ov3, busy3;
    logic signed [23:0] raw0, raw3;

    always #5 clk = ~clk;

    boreal_eeg_spi_rx u0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .drdy_n(drdy_n), .spi_miso(spi_miso),
        .spi_sclk(sclk0), .spi_cs_n(csn0), .raw_eeg_out(raw0), .data_valid(dv0),
        .frame_err(fe0), .overrun(ov0), .busy(busy0));

    boreal_eeg_spi_rx #(.SCLK_DIV(D), .NUM_CH(NCH), .CH_SEL(SEL3)) u3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .drdy_n(drdy_n), .spi_miso(spi_miso),
        .spi_sclk(sclk3), .spi_cs_n(csn3), .raw_eeg_out(raw3), .data_valid(dv3),
        .frame_err(fe3), .overrun(ov3), .busy(busy3));

    // Frame content presented by the ADC model; changed only between frames.
    logic [23:0] words [0:NCH];

    // ADC model: mode 1, next bit launched on each SCLK rising edge.
    int bidx = 0, pulses = 0;
    always @(posedge sclk0 or negedge csn0) begin
        if (sclk0) begin
            if (bidx < NB) spi_miso = words[bidx / 24][23 - (bidx % 24)];
            bidx++;
            pulses++;
        end else begin
            bidx   = 0;
            pulses = 0;
        end
    end

    // Reference model state
    bit a0 = 1'b1, a1 = 1'b1, a2 = 1'b1;   // drdy_n seen through two flops plus edge history
    int cyc = 0, fs = 0;
    bit m_act = 1'b0;
    logic [23:0] m_raw0 = '0, m_raw3 = '0;
    int p_chk = 0, p_pass = 0, l_chk = 0, l_pass = 0;
    int dv_cnt = 0, fe_cnt = 0, ov_cnt = 0, csl_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0 <= 1'b1; a1 <= 1'b1; a2 <= 1'b1;
        end else begin
            a0 <= drdy_n; a1 <= a0; a2 <= a1;
        end
        cyc <= cyc + 1;
    end

    // Per-cycle comparison against the frame-timing model.
    always @(negedge clk) begin
        logic fall, bm, pub, ok, e_cs, e_sclk, e_dv, e_fe, e_ov;
        logic [23:0] r0, r3;
        logic [29:0] e0, e3, g0, g3;
        int off;
        fall = 1'b0; pub = 1'b0; ok = 1'b1; off = 0;
        if (!rst_n) begin
            m_act <= 1'b0;
            r0 = '0; r3 = '0;
            bm = 1'b0; e_cs = 1'b1; e_sclk = 1'b0; e_dv = 1'b0; e_fe = 1'b0; e_ov = 1'b0;
        end else begin
            fall   = a2 & ~a1;
            off    = cyc - fs;
            bm     = m_act && off < L;
            e_cs   = !(bm && off <= L - 2);
            e_sclk = bm && off >= D && off < D + 2 * D * NB && (((off - D) / D) % 2 == 0);
            pub    = bm && off == L - 1;
`ifdef BOREAL_STATUS_CHECK_EN
            ok     = (words[0][23:20] == 4'hC);
`endif
            r0     = (pub && ok) ? words[1] : m_raw0;
            r3     = (pub && ok) ? words[1 + SEL3] : m_raw3;
            e_dv   = pub && ok;
            e_fe   = pub && !ok;
            e_ov   = fall && bm;
            if (fall && !bm && enable) begin
                m_act <= 1'b1;
                fs    <= cyc + 1;
            end
        end
        m_raw0 <= r0;
        m_raw3 <= r3;
        e0 = {e_cs, e_sclk, bm, e_dv, e_fe, e_ov, r0};
        e3 = {e_cs, e_sclk, bm, e_dv, e_fe, e_ov, r3};
        g0 = {csn0, sclk0, busy0, dv0, fe0, ov0, raw0};
        g3 = {csn3, sclk3, busy3, dv3, fe3, ov3, raw3};
        p_chk = p_chk + 2;
        if (g0 === e0) p_pass++;
        else $display("FAIL cyc_u0 @%0d: got %h want %h (cs,sclk,busy,dv,fe,ov,raw)", cyc, g0, e0);
        if (g3 === e3) p_pass++;
        else $display("FAIL cyc_u3 @%0d: got %h want %h (cs,sclk,busy,dv,fe,ov,raw)", cyc, g3, e3);
        dv_cnt  <= dv_cnt + int'(dv0);
        fe_cnt  <= fe_cnt + int'(fe0);
        ov_cnt  <= ov_cnt + int'(ov0);
        csl_cnt <= csl_cnt + int'(!csn0);
    end

    task automatic lchk(string nm, logic [31:0] act, logic [31:0] exp);
        l_chk++;
        if (act === exp) l_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drdy_pulse();
        drdy_n = 1'b0;
        step(3);
        drdy_n = 1'b1;
    endtask

    task automatic fill(logic [23:0] st, logic [23:0] other);
        words[0] = st;
        for (int i = 1; i <= NCH; i++) words[i] = other;
    endtask

    initial begin
        int dv_b, fe_b, ov_b, cs_b, ext, mode;
        fill(24'hC00000, 24'h0);
        step(5);
        lchk("reset_cs_n", 32'(csn0), 1);
        lchk("reset_raw", 32'(raw0[23:0]), 0);
        rst_n = 1'b1;
        step(5);

        // Defaults: status OK, ch0 = 0x008000
        fill(24'hC00000, 24'h111111);
        words[1] = 24'h008000;
        dv_b = dv_cnt;
        drdy_pulse(); step(L + 10);
        lchk("f1_pulses", pulses, 216);
        lchk("f1_cs_high", 32'(csn0), 1);
        lchk("f1_raw0", 32'(raw0[23:0]), 32'h008000);
        lchk("f1_dv_once", dv_cnt - dv_b, 1);

        // Bad status word
        fill(24'h400000, 24'h222222);
        words[1] = 24'h123456;
        dv_b = dv_cnt; fe_b = fe_cnt;
        drdy_pulse(); step(L + 10);
`ifdef BOREAL_STATUS_CHECK_EN
        lchk("bad_fe", fe_cnt - fe_b, 1);
        lchk("bad_no_dv", dv_cnt - dv_b, 0);
        lchk("bad_raw_kept", 32'(raw0[23:0]), 32'h008000);
`else
        lchk("bad_dv", dv_cnt - dv_b, 1);
        lchk("bad_no_fe", fe_cnt - fe_b, 0);
        lchk("bad_raw_new", 32'(raw0[23:0]), 32'h123456);
`endif

        // Negative sample on channel 3
        fill(24'hC00000, 24'h7FFFFF);
        words[1 + SEL3] = 24'h800001;
        dv_b = dv_cnt;
        drdy_pulse(); step(L + 10);
        lchk("ch3_raw", 32'(raw3[23:0]), 32'h800001);
        lchk("ch3_neg", 32'(raw3 < 0), 1);
        lchk("ch0_raw", 32'(raw0[23:0]), 32'h7FFFFF);
        lchk("ch3_dv_once", dv_cnt - dv_b, 1);

        // Second drdy edge ~100 cycles into a frame
        fill(24'hC12345, 24'h0ABCDE);
        dv_b = dv_cnt; ov_b = ov_cnt;
        drdy_pulse(); step(97);
        drdy_pulse(); step(L + 10);
        lchk("ovr_once", ov_cnt - ov_b, 1);
        lchk("ovr_pulses", pulses, 216);
        lchk("ovr_dv_once", dv_cnt - dv_b, 1);

        // Reset at SCLK pulse 50
        fill(24'hC00000, 24'h345678);
        dv_b = dv_cnt;
        drdy_pulse();
        for (int i = 0; i < 3000 && pulses < 50; i++) step(1);
        lchk("reach_pulse50", 32'(pulses >= 50), 1);
        rst_n = 1'b0;
        #1;
        lchk("rst_cs_n", 32'(csn0), 1);
        lchk("rst_sclk", 32'(sclk0), 0);
        lchk("rst_busy", 32'(busy0), 0);
        step(3);
        rst_n = 1'b1;
        step(20);
        lchk("rst_no_dv", dv_cnt - dv_b, 0);
        drdy_pulse(); step(L + 10);
        lchk("post_rst_dv", dv_cnt - dv_b, 1);
        lchk("post_rst_pulses", pulses, 216);
        lchk("post_rst_raw", 32'(raw0[23:0]), 32'h345678);

        // Disabled: edges are ignored quietly
        enable = 1'b0;
        dv_b = dv_cnt; ov_b = ov_cnt; cs_b = csl_cnt;
        for (int i = 0; i < 3; i++) begin drdy_pulse(); step(10); end
        lchk("dis_cs_n", csl_cnt - cs_b, 0);
        lchk("dis_no_ovr", ov_cnt - ov_b, 0);
        lchk("dis_no_dv", dv_cnt - dv_b, 0);
        enable = 1'b1;
        step(10);

        // Randomised frames with optional overrun or mid-frame disable
        for (int f = 0; f < 6; f++) begin
            words[0] = {($urandom_range(0, 1) != 0) ? 4'hC : 4'($urandom), 20'($urandom)};
            for (int i = 1; i <= NCH; i++) words[i] = 24'($urandom);
            ext  = $urandom_range(20, 1500);
            mode = $urandom_range(0, 2);
            drdy_pulse(); step(ext);
            if (mode == 1)      drdy_pulse();
            else if (mode == 2) enable = 1'b0;
            step(L + 10 - ext);
            enable = 1'b1;
            step(5);
        end

        $display("%0d/%0d checks passed", p_pass + l_pass, p_chk + l_chk);
        $finish;
    end
endmodule
